// File: rtl/uart_byte_tx.sv
// Byte-wide UART transmitter: accepts a byte on a valid/ready handshake
// and shifts it out LSB first as 8N1 or 8N2 on an idle-high line.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       DataValid,
  output logic       ReadyToSend,
  output logic       TxOut,
  output logic       Busy,
  output logic       TxDone
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          stop_idx;
  logic          wrap;
  logic          accept;

  assign wrap        = (cnt == CNT_MAX);
  assign ReadyToSend = (state == IDLE);
  assign Busy        = (state != IDLE);
  assign accept      = DataValid & ReadyToSend;

  // Bit timer runs only inside a frame; it sits at 0 in IDLE
  // so the start bit gets a full CLKS_PER_BIT cycles.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      TxOut    <= 1'b1;
      TxDone   <= 1'b0;
      idx      <= 3'd0;
      shreg    <= 8'h00;
      stop_idx <= 1'b0;
    end else begin
      TxDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            shreg    <= DataIn;
            TxOut    <= 1'b0;
            idx      <= 3'd0;
            stop_idx <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (wrap) begin
            TxOut <= shreg[0];
            idx   <= 3'd0;
            state <= DATA;
          end
        end
        DATA: begin
          if (wrap) begin
            if (idx == 3'd7) begin
              TxOut <= 1'b1;
              state <= STOP;
            end else begin
              // Bit 0 is always the one on the line next.
              shreg <= {1'b0, shreg[7:1]};
              TxOut <= shreg[1];
              idx   <= idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (wrap) begin
            if (stop_idx == STOP_LAST) begin
              TxDone <= 1'b1;
              state  <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: three instances cover (4,1), (4,2) and
// (2,1) for CLKS_PER_BIT/STOP_BITS against a bit-index line model.
module tb_uart_byte_tx;

  localparam int CPB [3] = '{4, 4, 2};
  localparam int SB  [3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din  [3];
  logic       dv   [3];
  logic       rdy  [3];
  logic       tx   [3];
  logic       busy [3];
  logic       done [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_byte_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u0 (
    .Clock(clk), .Reset(rst_n),
    .DataIn(din[0]), .DataValid(dv[0]),
    .ReadyToSend(rdy[0]), .TxOut(tx[0]),
    .Busy(busy[0]), .TxDone(done[0])
  );

  uart_byte_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u1 (
    .Clock(clk), .Reset(rst_n),
    .DataIn(din[1]), .DataValid(dv[1]),
    .ReadyToSend(rdy[1]), .TxOut(tx[1]),
    .Busy(busy[1]), .TxDone(done[1])
  );

  uart_byte_tx #(.CLKS_PER_BIT(2), .STOP_BITS(1)) u2 (
    .Clock(clk), .Reset(rst_n),
    .DataIn(din[2]), .DataValid(dv[2]),
    .ReadyToSend(rdy[2]), .TxOut(tx[2]),
    .Busy(busy[2]), .TxDone(done[2])
  );

  // Line level in cycle k (k=1 is the cycle after acceptance):
  // bit slot 0 is start, 1..8 data LSB first, later slots stop.
  function automatic logic exp_bit(
    input logic [7:0] d, input int k, input int c);
    int b;
    b = (k - 1) / c;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  function automatic int frame_len(input int u);
    return (9 + SB[u]) * CPB[u];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      dv[u]  = 1'b0;
      din[u] = 8'h00;
    end
    repeat (3) cyc();
    for (int u = 0; u < 3; u++) begin
      tests++;
      if (tx[u] !== 1'b1 || rdy[u] !== 1'b1 ||
          busy[u] !== 1'b0 || done[u] !== 1'b0) begin
        fails++;
        $display("FAIL reset u%0d tx=%b rdy=%b busy=%b done=%b exp 1 1 0 0",
                 u, tx[u], rdy[u], busy[u], done[u]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_a5();
    logic [7:0] d;
    int len;
    d = 8'hA5;
    len = frame_len(0);
    din[0] = d;
    dv[0] = 1'b1;
    cyc();
    dv[0] = 1'b0;
    for (int k = 1; k <= len; k++) begin
      tests++;
      if (tx[0] !== exp_bit(d, k, CPB[0])) begin
        fails++;
        $display("FAIL a5_bit cyc=%0d tx=%b exp=%b",
                 k, tx[0], exp_bit(d, k, CPB[0]));
      end
      tests++;
      if (busy[0] !== 1'b1 || done[0] !== 1'b0 || rdy[0] !== 1'b0) begin
        fails++;
        $display("FAIL a5_flags cyc=%0d busy=%b done=%b rdy=%b exp 1 0 0",
                 k, busy[0], done[0], rdy[0]);
      end
      cyc();
    end
    tests++;
    if (done[0] !== 1'b1 || busy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      fails++;
      $display("FAIL a5_done cyc=%0d done=%b busy=%b rdy=%b exp 1 0 1",
               len + 1, done[0], busy[0], rdy[0]);
    end
    cyc();
    tests++;
    if (done[0] !== 1'b0 || tx[0] !== 1'b1) begin
      fails++;
      $display("FAIL a5_after done=%b tx=%b exp 0 1", done[0], tx[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [2];
    int len;
    d[0] = 8'h00;
    d[1] = 8'hFF;
    len = frame_len(0);
    din[0] = d[0];
    dv[0] = 1'b1;
    cyc();
    din[0] = d[1];
    for (int f = 0; f < 2; f++) begin
      for (int k = 1; k <= len; k++) begin
        tests++;
        if (tx[0] !== exp_bit(d[f], k, CPB[0]) ||
            done[0] !== 1'b0) begin
          fails++;
          $display("FAIL b2b_bit f=%0d cyc=%0d tx=%b done=%b exp %b 0",
                   f, k, tx[0], done[0], exp_bit(d[f], k, CPB[0]));
        end
        cyc();
      end
      tests++;
      if (done[0] !== 1'b1 || rdy[0] !== 1'b1) begin
        fails++;
        $display("FAIL b2b_done f=%0d done=%b rdy=%b exp 1 1",
                 f, done[0], rdy[0]);
      end
      cyc();
      dv[0] = 1'b0;
    end
    tests++;
    if (busy[0] !== 1'b0 || tx[0] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_idle busy=%b tx=%b exp 0 1", busy[0], tx[0]);
    end
  endtask

  task automatic test_data_change();
    logic [7:0] d [2];
    int len;
    d[0] = 8'h3C;
    d[1] = 8'hC3;
    len = frame_len(0);
    din[0] = d[0];
    dv[0] = 1'b1;
    cyc();
    dv[0] = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 1; k <= len; k++) begin
        if (f == 0 && k == 10) begin
          din[0] = d[1];
          dv[0] = 1'b1;
        end
        tests++;
        if (tx[0] !== exp_bit(d[f], k, CPB[0])) begin
          fails++;
          $display("FAIL chg_bit f=%0d cyc=%0d tx=%b exp=%b",
                   f, k, tx[0], exp_bit(d[f], k, CPB[0]));
        end
        cyc();
      end
      tests++;
      if (done[0] !== 1'b1) begin
        fails++;
        $display("FAIL chg_done f=%0d done=%b exp 1", f, done[0]);
      end
      cyc();
      dv[0] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int len;
    d = 8'h55;
    len = frame_len(0);
    din[0] = d;
    dv[0] = 1'b1;
    cyc();
    dv[0] = 1'b0;
    for (int k = 1; k < 18; k++) cyc();
    tests++;
    if (tx[0] !== exp_bit(d, 18, CPB[0]) || busy[0] !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre tx=%b busy=%b exp %b 1",
               tx[0], busy[0], exp_bit(d, 18, CPB[0]));
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 ||
        rdy[0] !== 1'b1 || done[0] !== 1'b0) begin
      fails++;
      $display("FAIL rst_async tx=%b busy=%b rdy=%b done=%b exp 1 0 1 0",
               tx[0], busy[0], rdy[0], done[0]);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      tests++;
      if (tx[0] !== 1'b1 || done[0] !== 1'b0) begin
        fails++;
        $display("FAIL rst_hold k=%0d tx=%b done=%b exp 1 0",
                 k, tx[0], done[0]);
      end
    end
    rst_n = 1'b1;
    d = 8'h81;
    din[0] = d;
    dv[0] = 1'b1;
    cyc();
    dv[0] = 1'b0;
    for (int k = 1; k <= len; k++) begin
      tests++;
      if (tx[0] !== exp_bit(d, k, CPB[0]) || done[0] !== 1'b0) begin
        fails++;
        $display("FAIL rst_81 cyc=%0d tx=%b done=%b exp %b 0",
                 k, tx[0], done[0], exp_bit(d, k, CPB[0]));
      end
      cyc();
    end
    tests++;
    if (done[0] !== 1'b1) begin
      fails++;
      $display("FAIL rst_81_done done=%b exp 1", done[0]);
    end
    cyc();
  endtask

  task automatic test_params(input int u, input logic [7:0] d);
    int len;
    len = frame_len(u);
    din[u] = d;
    dv[u] = 1'b1;
    cyc();
    dv[u] = 1'b0;
    for (int k = 1; k <= len; k++) begin
      tests++;
      if (tx[u] !== exp_bit(d, k, CPB[u]) ||
          busy[u] !== 1'b1 || done[u] !== 1'b0) begin
        fails++;
        $display("FAIL param_u%0d cyc=%0d tx=%b busy=%b done=%b exp %b 1 0",
                 u, k, tx[u], busy[u], done[u], exp_bit(d, k, CPB[u]));
      end
      cyc();
    end
    tests++;
    if (done[u] !== 1'b1 || busy[u] !== 1'b0) begin
      fails++;
      $display("FAIL param_done_u%0d cyc=%0d done=%b busy=%b exp 1 0",
               u, len + 1, done[u], busy[u]);
    end
    cyc();
  endtask

  task automatic test_random();
    logic [7:0] d;
    int len;
    for (int u = 0; u < 3; u++) begin
      for (int n = 0; n < 4; n++) begin
        d = 8'($urandom_range(0, 255));
        len = frame_len(u);
        repeat ($urandom_range(0, 3)) cyc();
        din[u] = d;
        dv[u] = 1'b1;
        cyc();
        dv[u] = 1'b0;
        din[u] = 8'($urandom_range(0, 255));
        for (int k = 1; k <= len; k++) begin
          tests++;
          if (tx[u] !== exp_bit(d, k, CPB[u])) begin
            fails++;
            $display("FAIL rand_u%0d d=%h cyc=%0d tx=%b exp=%b",
                     u, d, k, tx[u], exp_bit(d, k, CPB[u]));
          end
          cyc();
        end
        tests++;
        if (done[u] !== 1'b1) begin
          fails++;
          $display("FAIL rand_done_u%0d d=%h done=%b exp 1",
                   u, d, done[u]);
        end
        cyc();
      end
    end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_data_change();
    test_reset_mid();
    test_params(1, 8'h01);
    test_params(2, 8'hF0);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, Clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter STOP_BITS, default 1, number of stop bits per frame; legal values 1 or 2.
REQ-003 Clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 DataIn  input  8  byte to transmit, sampled only at acceptance.
REQ-006 DataValid  input  1  upstream byte serializer has a byte on DataIn.
REQ-007 ReadyToSend  output  1  block can accept a byte this cycle.
REQ-008 TxOut  output  1  serial line, idle-high, 8N1 (or 8N2) framing, LSB first.
REQ-009 Busy  output  1  high while a frame is being shifted out.
REQ-010 TxDone  output  1  one-cycle pulse marking the end of a frame.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-012 ReadyToSend SHALL be high only when the state is IDLE.
REQ-013 A byte SHALL be accepted on a rising edge where DataValid and ReadyToSend are both high; DataIn is latched into an internal 8-bit shift register on that edge.
REQ-014 On acceptance the state SHALL become START, TxOut SHALL be 0 from the next cycle, and Busy SHALL be 1 from the next cycle.
REQ-015 TxOut SHALL be a registered output with no combinational path from any input.
REQ-016 Each start, data and stop bit SHALL be held on TxOut for exactly CLKS_PER_BIT cycles, timed by a bit counter of width clog2(CLKS_PER_BIT) that counts 0..CLKS_PER_BIT-1 and wraps to 0.
REQ-017 START->DATA SHALL occur when the bit counter wraps; DATA SHALL drive DataIn[0] first through DataIn[7] last, tracked by a 3-bit index.
REQ-018 DATA->STOP SHALL occur when the counter wraps with index 7; STOP SHALL drive TxOut=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-019 On the final STOP cycle's edge, the state SHALL return to IDLE; TxDone SHALL be high for exactly the first IDLE cycle, and Busy SHALL drop in that same cycle.
REQ-020 In the first IDLE cycle ReadyToSend SHALL be high; if DataValid is high then, the next byte SHALL be accepted, giving a back-to-back frame period of (1+8+STOP_BITS)*CLKS_PER_BIT+1 cycles.
REQ-021 Changes on DataIn or DataValid while not in IDLE SHALL have no effect on the frame in progress.
REQ-022 DataValid high while ReadyToSend is low SHALL NOT be lost; upstream holds it, and it is accepted when IDLE is reached.
REQ-023 Frame length, in Clock cycles from acceptance edge to TxDone, SHALL be exactly (9+STOP_BITS)*CLKS_PER_BIT.

Reset
REQ-024 While Reset is low, the block SHALL hold: state=IDLE, TxOut=1, ReadyToSend=1, Busy=0, TxDone=0, counter=0, index=0, shift register=0x00.
REQ-025 Reset asserted mid-frame SHALL force TxOut=1 immediately, without waiting for a clock edge, and SHALL abort the frame with no TxDone pulse.
REQ-026 After Reset deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-027 Send DataIn=0xA5 with one DataValid pulse. TxOut must read 0 (4 cycles), then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles). TxDone must be high at cycle 41 after acceptance.
REQ-028 Hold DataValid high with 0x00, then 0xFF. Two frames must be produced, with the second acceptance in the TxDone cycle and a 41-cycle period.
REQ-029 Change DataIn from 0x3C to 0xC3 at cycle 10 of a frame. The serialized bits must still match 0x3C.
REQ-030 Assert Reset low at cycle 18 of a frame of 0x55, between clock edges. TxOut must be 1 before the next edge, with no TxDone. A fresh 0x81 sent after reset must transmit correctly.
REQ-031 Set STOP_BITS=2 and send 0x01. The stop phase must last 8 cycles, and TxDone must be high at cycle 45.
REQ-032 Set CLKS_PER_BIT=2 and send 0xF0. Each bit must last exactly 2 cycles, with no counter wrap error.
